gate_scheduler: RTL

//  - Shares one barrier gate between an entry-lane and an exit-lane requester.
//  - Tracks lot occupancy from the car_enter/car_exit pulses of the sensor FSM.
//  - Sits above the a/b sensor-pair FSM; drives the barrier motor enable and lot-status lamps.

---
 rtl/gate_pkg.sv | 14 +
 rtl/occ_counter.sv | 35 +++
 rtl/gate_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared encodings for the barrier-gate scheduler: FSM states and lane identifiers.
package gate_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        CLOSE    = 2'd3
    } state_t;

    localparam logic LANE_IN  = 1'b0;
    localparam logic LANE_OUT = 1'b1;

endpackage

// File: rtl/occ_counter.sv
// Saturating up/down lot-occupancy counter; flags attempts to go past either bound.
module occ_counter #(
    parameter int CAPACITY = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    assign full  = (count == CAP);
    assign empty = (count == '0);
    // Simultaneous inc and dec cancel, so neither can over/underflow.
    assign ovf   = inc & ~dec & full;
    assign unf   = dec & ~inc & empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/gate_scheduler.sv
// Arbitrates one barrier gate between entry and exit lanes, with open-timeout,
// post-service hold-off and occupancy tracking from the sensor pulses.
module gate_scheduler
    import gate_pkg::*;
#(
    parameter int CAPACITY     = 16,
    parameter int CNT_W        = 5,
    parameter int OPEN_CYCLES  = 1000,
    parameter int CLOSE_CYCLES = 50,
    parameter int TMR_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             car_enter,
    input  logic             car_exit,
    output logic             gate_open,
    output logic             grant_in,
    output logic             grant_out,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             timeout,
    output logic             err
);

    localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYCLES - 1);

    state_t           state, state_n;
    logic [TMR_W-1:0] timer;
    logic             last_served;
    logic             timeout_n;
    logic             elig_in, elig_out;
    logic             ovf, unf, stray;

    occ_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .inc   (car_enter),
        .dec   (car_exit),
        .count (occupancy),
        .full  (full),
        .empty (empty),
        .ovf   (ovf),
        .unf   (unf)
    );

    assign elig_in  = req_in & ~full;
    assign elig_out = req_out & ~empty;
    assign stray    = (car_enter && state != OPEN_IN) || (car_exit && state != OPEN_OUT);

    always_comb begin
        state_n   = state;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                // On a tie, serve the lane that did not go last.
                if (elig_in && elig_out)
                    state_n = (last_served == LANE_IN) ? OPEN_OUT : OPEN_IN;
                else if (elig_in)
                    state_n = OPEN_IN;
                else if (elig_out)
                    state_n = OPEN_OUT;
            end
            OPEN_IN: begin
                if (car_enter) begin
                    state_n = CLOSE;
                end else if (timer == OPEN_LAST) begin
                    state_n   = CLOSE;
                    timeout_n = 1'b1;
                end
            end
            OPEN_OUT: begin
                if (car_exit) begin
                    state_n = CLOSE;
                end else if (timer == OPEN_LAST) begin
                    state_n   = CLOSE;
                    timeout_n = 1'b1;
                end
            end
            CLOSE: begin
                if (timer == CLOSE_LAST)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            timer       <= '0;
            last_served <= LANE_OUT;
            gate_open   <= 1'b0;
            grant_in    <= 1'b0;
            grant_out   <= 1'b0;
            timeout     <= 1'b0;
            err         <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= (state_n != state || state == IDLE) ? '0 : timer + 1'b1;
            // Outputs decoded from the next state so they line up with the new state.
            gate_open <= (state_n == OPEN_IN) || (state_n == OPEN_OUT);
            grant_in  <= (state_n == OPEN_IN);
            grant_out <= (state_n == OPEN_OUT);
            timeout   <= timeout_n;
            err       <= err | ovf | unf | stray;
            if (state_n == CLOSE && state != CLOSE)
                last_served <= (state == OPEN_OUT) ? LANE_OUT : LANE_IN;
        end
    end

endmodule
